// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcode/funct
// constants, datapath select encodings and the decoded-instruction record.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_BOEZ  = 6'h1e;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_XOR = 3'b010, ALU_OR = 3'b011, ALU_SLL = 3'b100
  } alu_op_e;

  typedef enum logic [2:0] {
    NPC_PC4 = 3'b000, NPC_BR = 3'b001, NPC_JMP = 3'b010, NPC_RS = 3'b100
  } npc_sel_e;

  typedef enum logic [2:0] {
    WB_ALU = 3'b000, WB_MEM = 3'b001, WB_EXT = 3'b010, WB_PC4 = 3'b011, WB_MEMB = 3'b100
  } wb_sel_e;

  typedef enum logic [2:0] {
    EXT_ZERO = 3'b000, EXT_SIGN = 3'b001, EXT_LUI = 3'b010
  } ext_op_e;

  typedef enum logic [1:0] {
    DST_RT = 2'b00, DST_RD = 2'b01, DST_RA = 2'b10
  } reg_dst_e;

  typedef struct packed {
    logic     r_alu;
    logic     j;
    logic     jr;
    logic     jal;
    logic     jalr;
    logic     beq;
    logic     bgtz;
    logic     boez;
    logic     lui;
    logic     ori;
    logic     addi;
    logic     lw;
    logic     lb;
    logic     sw;
    logic     illegal;
    alu_op_e  alu_op;
    logic     alu_src;
    ext_op_e  ext_op;
    wb_sel_e  wb_sel;
    reg_dst_e reg_dst;
  } dec_t;

  function automatic logic br_taken(input dec_t d, input logic eq, input logic gtz, input logic oez);
    return (d.beq & eq) | (d.bgtz & gtz) | (d.boez & oez);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: opcode/funct -> instruction-class flags
// plus the static ALU/extender/write-back selects for that instruction.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output dec_t       o_dec
);

  // Classify the instruction held in IR
  always_comb begin
    o_dec         = '0;
    o_dec.alu_op  = ALU_ADD;
    o_dec.ext_op  = EXT_ZERO;
    o_dec.wb_sel  = WB_ALU;
    o_dec.reg_dst = DST_RT;
    case (i_opcode)
      OP_RTYPE: begin
        o_dec.reg_dst = DST_RD;
        case (i_funct)
          FN_SLL:          begin o_dec.r_alu = 1'b1; o_dec.alu_op = ALU_SLL; end
          FN_ADD, FN_ADDU: begin o_dec.r_alu = 1'b1; o_dec.alu_op = ALU_ADD; end
          FN_SUB, FN_SUBU: begin o_dec.r_alu = 1'b1; o_dec.alu_op = ALU_SUB; end
          FN_OR:           begin o_dec.r_alu = 1'b1; o_dec.alu_op = ALU_OR;  end
          FN_XOR:          begin o_dec.r_alu = 1'b1; o_dec.alu_op = ALU_XOR; end
          FN_JR:           o_dec.jr = 1'b1;
          FN_JALR:         begin o_dec.jalr = 1'b1; o_dec.wb_sel = WB_PC4; end
          default:         o_dec.illegal = 1'b1;
        endcase
      end
      OP_J:    o_dec.j = 1'b1;
      OP_JAL:  begin o_dec.jal = 1'b1; o_dec.wb_sel = WB_PC4; o_dec.reg_dst = DST_RA; end
      OP_BEQ:  begin o_dec.beq  = 1'b1; o_dec.alu_op = ALU_SUB; o_dec.ext_op = EXT_SIGN; end
      OP_BGTZ: begin o_dec.bgtz = 1'b1; o_dec.alu_op = ALU_SUB; o_dec.ext_op = EXT_SIGN; end
      OP_BOEZ: begin o_dec.boez = 1'b1; o_dec.alu_op = ALU_SUB; o_dec.ext_op = EXT_SIGN; end
      OP_LUI:  begin o_dec.lui  = 1'b1; o_dec.ext_op = EXT_LUI; o_dec.wb_sel = WB_EXT; end
      OP_ORI:  begin o_dec.ori  = 1'b1; o_dec.alu_op = ALU_OR; o_dec.alu_src = 1'b1; end
      OP_ADDI: begin o_dec.addi = 1'b1; o_dec.alu_src = 1'b1; o_dec.ext_op = EXT_SIGN; end
      OP_LW:   begin o_dec.lw = 1'b1; o_dec.alu_src = 1'b1; o_dec.ext_op = EXT_SIGN; o_dec.wb_sel = WB_MEM;  end
      OP_LB:   begin o_dec.lb = 1'b1; o_dec.alu_src = 1'b1; o_dec.ext_op = EXT_SIGN; o_dec.wb_sel = WB_MEMB; end
      OP_SW:   begin o_dec.sw = 1'b1; o_dec.alu_src = 1'b1; o_dec.ext_op = EXT_SIGN; end
      default: o_dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with shared-memory-port timeout.
// Optional macro MC_PERF_CNT_EN adds cycle / retired-instruction counters (width CNT_W).
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
`ifdef MC_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [5:0]       i_opcode,
  input  logic [5:0]       i_funct,
  input  logic             i_br_eq,
  input  logic             i_br_gtz,
  input  logic             i_br_oez,
  input  logic             i_mem_ready,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic             o_mem_ifetch,
  output logic             o_ir_we,
  output logic             o_pc_we,
  output logic [2:0]       o_npc_sel,
  output logic [2:0]       o_alu_op,
  output logic             o_alu_src,
  output logic [2:0]       o_ext_op,
  output logic             o_reg_we,
  output logic [1:0]       o_reg_dst,
  output logic [2:0]       o_wb_sel,
  output logic             o_illegal,
  output logic             o_bus_err
`ifdef MC_PERF_CNT_EN
  , output logic [CNT_W-1:0] o_cyc_cnt
  , output logic [CNT_W-1:0] o_ins_cnt
`endif
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] TMO_VAL = WAIT_W'(MEM_TIMEOUT);
  localparam bit TMO_EN = (MEM_TIMEOUT != 0);

  state_e            r_state, w_state_nxt;
  logic [WAIT_W-1:0] r_wait, w_wait_nxt;
  dec_t              w_dec;
  logic              w_tmo_hit;
  logic              w_mem_req, w_mem_we, w_mem_ifetch, w_ir_we, w_pc_we, w_alu_src;
  logic              w_reg_we, w_illegal, w_bus_err;
  npc_sel_e          w_npc_sel;
  alu_op_e           w_alu_op;
  ext_op_e           w_ext_op;
  reg_dst_e          w_reg_dst;
  wb_sel_e           w_wb_sel;

  mc_decode u_decode (
    .i_opcode (i_opcode),
    .i_funct  (i_funct),
    .o_dec    (w_dec)
  );

  assign w_tmo_hit = TMO_EN && (r_wait == TMO_VAL);

  // State register and memory-wait counter
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_FETCH;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  // Next state and control decode; the wait counter restarts whenever a
  // memory state is (re)entered, so it only advances while a request stalls
  always_comb begin
    w_state_nxt  = r_state;
    w_wait_nxt   = '0;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_ifetch = 1'b0;
    w_ir_we      = 1'b0;
    w_pc_we      = 1'b0;
    w_npc_sel    = NPC_PC4;
    w_alu_op     = ALU_ADD;
    w_alu_src    = 1'b0;
    w_ext_op     = EXT_ZERO;
    w_reg_we     = 1'b0;
    w_reg_dst    = DST_RT;
    w_wb_sel     = WB_ALU;
    w_illegal    = 1'b0;
    w_bus_err    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_mem_req    = 1'b1;
        w_mem_ifetch = 1'b1;
        if (i_mem_ready) begin
          w_ir_we     = 1'b1;
          w_state_nxt = ST_DECODE;
        end else if (w_tmo_hit) begin
          w_mem_req   = 1'b0;
          w_bus_err   = 1'b1;
          w_state_nxt = ST_FETCH;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end
      ST_DECODE: begin
        if (w_dec.illegal) begin
          w_illegal   = 1'b1;
          w_pc_we     = 1'b1;
          w_state_nxt = ST_FETCH;
        end else if (w_dec.j | w_dec.jr | w_dec.jal | w_dec.jalr) begin
          w_pc_we     = 1'b1;
          w_npc_sel   = (w_dec.jr | w_dec.jalr) ? NPC_RS : NPC_JMP;
          w_state_nxt = ST_FETCH;
          if (w_dec.jal | w_dec.jalr) begin
            w_reg_we  = 1'b1;
            w_reg_dst = w_dec.reg_dst;
            w_wb_sel  = w_dec.wb_sel;
          end else begin
            w_reg_we  = 1'b0;
          end
        end else if (w_dec.lui) begin
          w_state_nxt = ST_WB;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_alu_op  = w_dec.alu_op;
        w_alu_src = w_dec.alu_src;
        w_ext_op  = w_dec.ext_op;
        if (w_dec.beq | w_dec.bgtz | w_dec.boez) begin
          w_pc_we     = 1'b1;
          w_npc_sel   = br_taken(w_dec, i_br_eq, i_br_gtz, i_br_oez) ? NPC_BR : NPC_PC4;
          w_state_nxt = ST_FETCH;
        end else if (w_dec.lw | w_dec.lb | w_dec.sw) begin
          w_state_nxt = ST_MEM;
        end else if (w_dec.r_alu | w_dec.ori | w_dec.addi) begin
          w_state_nxt = ST_WB;
        end else begin
          w_pc_we     = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_MEM: begin
        w_alu_op  = w_dec.alu_op;
        w_alu_src = w_dec.alu_src;
        w_ext_op  = w_dec.ext_op;
        w_mem_req = 1'b1;
        w_mem_we  = w_dec.sw;
        if (i_mem_ready) begin
          w_pc_we     = w_dec.sw;
          w_state_nxt = w_dec.sw ? ST_FETCH : ST_WB;
        end else if (w_tmo_hit) begin
          w_mem_req   = 1'b0;
          w_mem_we    = 1'b0;
          w_bus_err   = 1'b1;
          w_state_nxt = ST_FETCH;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end
      ST_WB: begin
        w_alu_op    = w_dec.alu_op;
        w_alu_src   = w_dec.alu_src;
        w_ext_op    = w_dec.ext_op;
        w_reg_we    = 1'b1;
        w_reg_dst   = w_dec.reg_dst;
        w_wb_sel    = w_dec.wb_sel;
        w_pc_we     = 1'b1;
        w_state_nxt = ST_FETCH;
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  // Reset forces every strobe low at once, including a request in flight
  assign o_mem_req    = w_mem_req    & ~i_reset;
  assign o_mem_we     = w_mem_we     & ~i_reset;
  assign o_mem_ifetch = w_mem_ifetch & ~i_reset;
  assign o_ir_we      = w_ir_we      & ~i_reset;
  assign o_pc_we      = w_pc_we      & ~i_reset;
  assign o_npc_sel    = w_npc_sel    & {3{~i_reset}};
  assign o_alu_op     = w_alu_op     & {3{~i_reset}};
  assign o_alu_src    = w_alu_src    & ~i_reset;
  assign o_ext_op     = w_ext_op     & {3{~i_reset}};
  assign o_reg_we     = w_reg_we     & ~i_reset;
  assign o_reg_dst    = w_reg_dst    & {2{~i_reset}};
  assign o_wb_sel     = w_wb_sel     & {3{~i_reset}};
  assign o_illegal    = w_illegal    & ~i_reset;
  assign o_bus_err    = w_bus_err    & ~i_reset;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] r_cyc_cnt, r_ins_cnt;

  // Free-running cycle count and retired-instruction count
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cyc_cnt <= '0;
      r_ins_cnt <= '0;
    end else begin
      r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
      if (w_pc_we) begin
        r_ins_cnt <= r_ins_cnt + CNT_W'(1);
      end else begin
        r_ins_cnt <= r_ins_cnt;
      end
    end
  end

  assign o_cyc_cnt = r_cyc_cnt;
  assign o_ins_cnt = r_ins_cnt;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller (MEM_TIMEOUT = 4).
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       br_eq, br_gtz, br_oez, mem_ready;
  logic       mem_req, mem_we, mem_ifetch, ir_we, pc_we, alu_src, reg_we, illegal, bus_err;
  logic [2:0] npc_sel, alu_op, ext_op, wb_sel;
  logic [1:0] reg_dst;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cyc_cnt, ins_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mc_controller #(.MEM_TIMEOUT(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_opcode(opcode), .i_funct(funct),
    .i_br_eq(br_eq), .i_br_gtz(br_gtz), .i_br_oez(br_oez), .i_mem_ready(mem_ready),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_ifetch(mem_ifetch), .o_ir_we(ir_we),
    .o_pc_we(pc_we), .o_npc_sel(npc_sel), .o_alu_op(alu_op), .o_alu_src(alu_src),
    .o_ext_op(ext_op), .o_reg_we(reg_we), .o_reg_dst(reg_dst), .o_wb_sel(wb_sel),
    .o_illegal(illegal), .o_bus_err(bus_err)
`ifdef MC_PERF_CNT_EN
    , .o_cyc_cnt(cyc_cnt), .o_ins_cnt(ins_cnt)
`endif
  );

  always #5 clk = ~clk;

  // {mem_req, mem_we, mem_ifetch, ir_we, pc_we, npc_sel, reg_we, reg_dst, wb_sel, illegal, bus_err}
  wire [15:0] ctl = {mem_req, mem_we, mem_ifetch, ir_we, pc_we, npc_sel,
                     reg_we, reg_dst, wb_sel, illegal, bus_err};
  wire [6:0]  alu = {alu_op, alu_src, ext_op};

  function automatic logic [15:0] pk(input logic rq, input logic we, input logic ifc,
                                     input logic irw, input logic pcw, input logic [2:0] npc,
                                     input logic rw, input logic [1:0] dst, input logic [2:0] wb,
                                     input logic ill, input logic be);
    return {rq, we, ifc, irw, pcw, npc, rw, dst, wb, ill, be};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Check control word for the current cycle, then advance one clock
  task automatic step(input string tag, input logic [15:0] exp);
    #1;
    chk(tag, 32'(ctl), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  logic [15:0] f_wait, f_rdy, idle, wb_r, m_wait;
  logic [5:0]  b_op  [6];
  logic [2:0]  b_in  [6];
  logic [2:0]  b_npc [6];

  initial begin
    f_wait = pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
    f_rdy  = pk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
    idle   = 16'h0000;
    wb_r   = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 2'b01, 3'b000, 1'b0, 1'b0);
    m_wait = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
    // branch table: opcode, {eq,gtz,oez}, expected npc_sel
    b_op  = '{6'h04, 6'h04, 6'h07, 6'h07, 6'h1e, 6'h1e};
    b_in  = '{3'b100, 3'b011, 3'b010, 3'b101, 3'b001, 3'b110};
    b_npc = '{3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000};

    reset = 1'b1; opcode = 6'h00; funct = 6'h00;
    br_eq = 1'b0; br_gtz = 1'b0; br_oez = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", 32'(ctl), 32'h0);
    chk("rst_alu", 32'(alu), 32'h0);
`ifdef MC_PERF_CNT_EN
    chk("rst_cyc", cyc_cnt, 32'd0);
`endif
    reset = 1'b0;

    // add: F D E W
    opcode = 6'h00; funct = 6'h20; mem_ready = 1'b1;
    step("add_f", f_rdy);
    step("add_d", idle);
    #1 chk("add_alu", 32'(alu), 32'(7'b000_0_000));
    step("add_e", idle);
    step("add_w", wb_r);
`ifdef MC_PERF_CNT_EN
    chk("perf_cyc", cyc_cnt, 32'd4);
    chk("perf_ins", ins_cnt, 32'd1);
`endif

    // lw with 3 FETCH and 2 MEM wait cycles: 10 cycles
    opcode = 6'h23; mem_ready = 1'b0;
    repeat (3) step("lw_fwait", f_wait);
    mem_ready = 1'b1;
    step("lw_frdy", f_rdy);
    step("lw_d", idle);
    #1 chk("lw_alu", 32'(alu), 32'(7'b000_1_001));
    step("lw_e", idle);
    mem_ready = 1'b0;
    repeat (2) step("lw_mwait", m_wait);
    mem_ready = 1'b1;
    step("lw_mrdy", m_wait);
    step("lw_w", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 2'b00, 3'b001, 1'b0, 1'b0));

    // branches: taken/not taken on each condition input
    for (int i = 0; i < 6; i++) begin
      opcode = b_op[i];
      {br_eq, br_gtz, br_oez} = b_in[i];
      step("br_f", f_rdy);
      step("br_d", idle);
      step("br_e", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, b_npc[i], 1'b0, 2'b00, 3'b000, 1'b0, 1'b0));
    end
    {br_eq, br_gtz, br_oez} = 3'b000;

    // jal, jr, illegal
    opcode = 6'h03;
    step("jal_f", f_rdy);
    step("jal_d", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 2'b10, 3'b011, 1'b0, 1'b0));
    opcode = 6'h00; funct = 6'h08;
    step("jr_f", f_rdy);
    step("jr_d", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0));
    opcode = 6'h3f;
    step("ill_f", f_rdy);
    step("ill_d", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0));

    // lui: F D W, ext imm written to rt
    opcode = 6'h0f;
    step("lui_f", f_rdy);
    step("lui_d", idle);
    #1 chk("lui_ext", 32'(ext_op), 32'(3'b010));
    step("lui_w", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 2'b00, 3'b010, 1'b0, 1'b0));

    // sub and ori ALU selects
    opcode = 6'h00; funct = 6'h22;
    step("sub_f", f_rdy);
    step("sub_d", idle);
    #1 chk("sub_alu", 32'(alu), 32'(7'b001_0_000));
    step("sub_e", idle);
    step("sub_w", wb_r);
    opcode = 6'h0d;
    step("ori_f", f_rdy);
    step("ori_d", idle);
    #1 chk("ori_alu", 32'(alu), 32'(7'b011_1_000));
    step("ori_e", idle);
    step("ori_w", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0));

    // FETCH timeout after 4 waits, retry, then ready on the limit cycle wins
    opcode = 6'h00; funct = 6'h20; mem_ready = 1'b0;
    repeat (4) step("to_wait", f_wait);
    step("to_err", pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1));
    step("to_retry", f_wait);
    repeat (3) step("to_wait2", f_wait);
    mem_ready = 1'b1;
    step("to_win", f_rdy);
    step("to_d", idle);
    step("to_e", idle);
    step("to_w", wb_r);

    // sw completes in 4 cycles
    opcode = 6'h2b;
    step("sw_f", f_rdy);
    step("sw_d", idle);
    step("sw_e", idle);
    step("sw_m", pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0));

    // reset while sw is stalled in MEM
    step("swr_f", f_rdy);
    step("swr_d", idle);
    step("swr_e", idle);
    mem_ready = 1'b0;
    #1 chk("swr_m", 32'(ctl), 32'(pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0)));
    reset = 1'b1;
    #1 chk("swr_rst", 32'(ctl), 32'h0);
    @(posedge clk);
    #1;
`ifdef MC_PERF_CNT_EN
    chk("swr_cyc", cyc_cnt, 32'd0);
    chk("swr_ins", ins_cnt, 32'd0);
`endif
    reset = 1'b0;
    step("swr_fetch", f_wait);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
